axi_sram_bridge_mc: RTL and testbench

Parametrised successor to the two-port SRAM-like-to-AXI transfer bridge. Bridges N_CH SRAM-like request channels (inst, data, and later cache/uncached ports) onto one AXI3 master port. Supports round-robin read arbitration, one outstanding read per channel routed back by RID, one outstanding write, and read-after-write address hazard blocking. Sits between the CPU core and the AXI interconnect inside the CPU top.

---
 rtl/axi_sram_bridge_mc.sv | 207 ++++++++++++++++++++
 tb/tb_axi_sram_bridge_mc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_bridge_mc.sv
// Multi-channel SRAM-like to AXI3 bridge: round-robin reads (one outstanding per channel,
// routed back by RID), a single write slot, and read-after-write address hazard blocking.
module axi_sram_bridge_mc #(
    parameter int N_CH = 2,
    parameter int ID_W = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [N_CH-1:0]      ch_req,
    input  logic [N_CH-1:0]      ch_wr,
    input  logic [2*N_CH-1:0]    ch_size,
    input  logic [32*N_CH-1:0]   ch_addr,
    input  logic [4*N_CH-1:0]    ch_wstrb,
    input  logic [32*N_CH-1:0]   ch_wdata,
    output logic [N_CH-1:0]      ch_addr_ok,
    output logic [N_CH-1:0]      ch_data_ok,
    output logic [32*N_CH-1:0]   ch_rdata,
    output logic [ID_W-1:0]      arid,
    output logic [31:0]          araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic [1:0]           arlock,
    output logic [3:0]           arcache,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [ID_W-1:0]      rid,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [ID_W-1:0]      awid,
    output logic [31:0]          awaddr,
    output logic [7:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic [1:0]           awlock,
    output logic [3:0]           awcache,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [ID_W-1:0]      wid,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [ID_W-1:0]      bid,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] rd_busy;
    logic            ar_full;
    logic [31:0]     ar_addr;
    logic [1:0]      ar_size;
    logic [PW-1:0]   ar_ch;
    logic [PW-1:0]   rr_ptr;

    logic            wr_full, aw_pend, w_pend;
    logic [31:0]     wr_addr, wr_data;
    logic [1:0]      wr_size;
    logic [3:0]      wr_strb;
    logic [PW-1:0]   wr_owner;

    logic [N_CH-1:0] hazard, rd_elig, wr_elig, rd_grant, wr_grant, rd_ret, wr_ret;
    logic            rd_found, wr_found;
    logic [PW-1:0]   rd_win, wr_win;

    always_comb begin
        hazard  = '0;
        rd_elig = '0;
        wr_elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            hazard[i]  = wr_full && (wr_addr[31:2] == ch_addr[32*i+2 +: 30]);
            rd_elig[i] = ch_req[i] && !ch_wr[i] && !rd_busy[i] && !ar_full && !hazard[i];
            wr_elig[i] = ch_req[i] && ch_wr[i] && !wr_full;
        end
    end

    // Round-robin search begins at rr_ptr and wraps modulo N_CH
    always_comb begin
        int idx;
        idx      = 0;
        rd_found = 1'b0;
        rd_win   = '0;
        rd_grant = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!rd_found && rd_elig[idx]) begin
                rd_found = 1'b1;
                rd_win   = PW'(idx);
            end
        end
        if (rd_found) rd_grant[rd_win] = 1'b1;
    end

    always_comb begin
        wr_found = 1'b0;
        wr_win   = '0;
        wr_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!wr_found && wr_elig[i]) begin
                wr_found = 1'b1;
                wr_win   = PW'(i);
            end
        end
        if (wr_found) wr_grant[wr_win] = 1'b1;
    end

    // Returns only count for a channel actually waiting; stale or out-of-range IDs are dropped
    always_comb begin
        rd_ret = '0;
        wr_ret = '0;
        for (int i = 0; i < N_CH; i++) begin
            rd_ret[i] = rvalid && (rid == ID_W'(i)) && rd_busy[i];
            wr_ret[i] = bvalid && wr_full && (wr_owner == PW'(i));
        end
    end

    assign ch_addr_ok = rd_grant | wr_grant;
    assign ch_data_ok = rd_ret | wr_ret;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_busy  <= '0;
            ar_full  <= 1'b0;
            ar_addr  <= '0;
            ar_size  <= '0;
            ar_ch    <= '0;
            rr_ptr   <= '0;
            ch_rdata <= '0;
            wr_full  <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_size  <= '0;
            wr_strb  <= '0;
            wr_owner <= '0;
        end else begin
            // AR slot frees on the handshake edge; a new grant can only see it empty next cycle
            if (ar_full && arready) begin
                ar_full <= 1'b0;
            end else if (rd_found) begin
                ar_full <= 1'b1;
                ar_addr <= ch_addr[32*int'(rd_win) +: 32];
                ar_size <= ch_size[2*int'(rd_win) +: 2];
                ar_ch   <= rd_win;
                rr_ptr  <= PW'((int'(rd_win) + 1) % N_CH);
            end
            rd_busy <= (rd_busy | rd_grant) & ~rd_ret;
            for (int i = 0; i < N_CH; i++) begin
                if (rd_ret[i]) ch_rdata[32*i +: 32] <= rdata;
            end

            if (wr_found) begin
                wr_full  <= 1'b1;
                aw_pend  <= 1'b1;
                w_pend   <= 1'b1;
                wr_addr  <= ch_addr[32*int'(wr_win) +: 32];
                wr_data  <= ch_wdata[32*int'(wr_win) +: 32];
                wr_size  <= ch_size[2*int'(wr_win) +: 2];
                wr_strb  <= ch_wstrb[4*int'(wr_win) +: 4];
                wr_owner <= wr_win;
            end else begin
                if (aw_pend && awready) aw_pend <= 1'b0;
                if (w_pend && wready)   w_pend  <= 1'b0;
                if (wr_full && bvalid)  wr_full <= 1'b0;
            end
        end
    end

    assign arid    = ID_W'(ar_ch);
    assign araddr  = ar_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, ar_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = ar_full;
    assign rready  = 1'b1;

    assign awid    = ID_W'(wr_owner);
    assign awaddr  = wr_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, wr_size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = aw_pend;
    assign wid     = ID_W'(wr_owner);
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;
    assign wlast   = 1'b1;
    assign wvalid  = w_pend;
    assign bready  = 1'b1;

    logic unused;
    assign unused = ^{rresp, rlast, bid, bresp};
endmodule

// File: tb/tb_axi_sram_bridge_mc.sv
// Directed bench for axi_sram_bridge_mc with three channels: arbitration, RID routing,
// write slot handshakes, RAW hazard blocking and asynchronous reset abandonment.
module tb_axi_sram_bridge_mc;
    localparam int N_CH = 3;
    localparam int ID_W = 4;

    logic                 aclk, aresetn;
    logic [N_CH-1:0]      ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [2*N_CH-1:0]    ch_size;
    logic [32*N_CH-1:0]   ch_addr, ch_wdata, ch_rdata;
    logic [4*N_CH-1:0]    ch_wstrb;
    logic [ID_W-1:0]      arid, rid, awid, wid, bid;
    logic [31:0]          araddr, rdata, awaddr, wdata;
    logic [7:0]           arlen, awlen;
    logic [2:0]           arsize, arprot, awsize, awprot;
    logic [1:0]           arburst, arlock, rresp, awburst, awlock, bresp;
    logic [3:0]           arcache, awcache, wstrb;
    logic                 arvalid, arready, rlast, rvalid, rready;
    logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_cmp = 0;
    int n_fail = 0;

    axi_sram_bridge_mc #(.N_CH(N_CH), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
        .ch_wstrb(ch_wstrb), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic rd(input int i, input logic [31:0] a, input logic [1:0] s);
        ch_req[i] = 1'b1;
        ch_wr[i]  = 1'b0;
        ch_addr[32*i +: 32] = a;
        ch_size[2*i +: 2]   = s;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [1:0] s,
                      input logic [3:0] st, input logic [31:0] d);
        ch_req[i] = 1'b1;
        ch_wr[i]  = 1'b1;
        ch_addr[32*i +: 32]  = a;
        ch_size[2*i +: 2]    = s;
        ch_wstrb[4*i +: 4]   = st;
        ch_wdata[32*i +: 32] = d;
    endtask

    task automatic clr(input int i);
        ch_req[i] = 1'b0;
        ch_wr[i]  = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wstrb = '0; ch_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

        #2;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_addr_ok", 32'(ch_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(ch_data_ok), 32'd0);
        chk("rst_rdata1", ch_rdata[63:32], 32'd0);
        chk("const_rready", 32'(rready), 32'd1);
        chk("const_arburst", 32'(arburst), 32'd1);
        #10 aresetn = 1'b1;

        // Three-way read arbitration from RR pointer 0
        tick(); rd(0, 32'h1000, 2); rd(1, 32'h2000, 2); rd(2, 32'h3000, 2); arready = 1'b1;
        settle(); chk("arb_g0", 32'(ch_addr_ok), 32'b001);
        tick(); clr(0);
        settle(); chk("arb_ar0_valid", 32'(arvalid), 32'd1); chk("arb_ar0_id", 32'(arid), 32'd0);
        chk("arb_bubble0", 32'(ch_addr_ok), 32'd0);
        tick();
        settle(); chk("arb_g1", 32'(ch_addr_ok), 32'b010);
        tick(); clr(1);
        settle(); chk("arb_ar1_id", 32'(arid), 32'd1); chk("arb_ar1_addr", araddr, 32'h2000);
        chk("arb_bubble1", 32'(ch_addr_ok), 32'd0);
        tick();
        settle(); chk("arb_g2", 32'(ch_addr_ok), 32'b100);
        tick(); clr(2);
        settle(); chk("arb_ar2_id", 32'(arid), 32'd2); chk("arb_ar2_addr", araddr, 32'h3000);

        // Out-of-order returns
        tick(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_1111;
        settle(); chk("ooo_dok1", 32'(ch_data_ok), 32'b010); chk("ooo_arvalid", 32'(arvalid), 32'd0);
        tick(); rid = 4'd0; rdata = 32'hA0A0_A0A0;
        settle(); chk("ooo_dok0", 32'(ch_data_ok), 32'b001);
        tick(); rid = 4'd2; rdata = 32'h2222_2222;
        settle(); chk("ooo_dok2", 32'(ch_data_ok), 32'b100);
        tick(); rvalid = 1'b0;
        settle(); chk("ooo_rdata0", ch_rdata[31:0], 32'hA0A0_A0A0);
        chk("ooo_rdata1", ch_rdata[63:32], 32'h1111_1111);
        chk("ooo_rdata2", ch_rdata[95:64], 32'h2222_2222);
        chk("ooo_dok_idle", 32'(ch_data_ok), 32'd0);

        // Second round, pointer back at 0, only ch1/ch2 requesting
        tick(); rd(1, 32'h4000, 2); rd(2, 32'h5000, 2); arready = 1'b1;
        settle(); chk("rr2_g1", 32'(ch_addr_ok), 32'b010);
        tick(); clr(1);
        settle(); chk("rr2_bubble", 32'(ch_addr_ok), 32'd0); chk("rr2_ar1_id", 32'(arid), 32'd1);
        tick();
        settle(); chk("rr2_g2", 32'(ch_addr_ok), 32'b100);
        tick(); clr(2);
        settle(); chk("rr2_ar2_id", 32'(arid), 32'd2);
        tick(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h4444_4444;
        settle(); chk("rr2_dok1", 32'(ch_data_ok), 32'b010);
        tick(); rid = 4'd2; rdata = 32'h5555_5555;
        settle(); chk("rr2_dok2", 32'(ch_data_ok), 32'b100);
        tick(); rvalid = 1'b0;

        // Single read, with an out-of-range RID and a busy re-request in between
        tick(); rd(0, 32'h1C00_0000, 2);
        settle(); chk("sr_aok", 32'(ch_addr_ok), 32'b001);
        tick(); clr(0); arready = 1'b1;
        settle(); chk("sr_arvalid", 32'(arvalid), 32'd1); chk("sr_arid", 32'(arid), 32'd0);
        chk("sr_araddr", araddr, 32'h1C00_0000); chk("sr_arsize", 32'(arsize), 32'b010);
        tick(); arready = 1'b0; rd(0, 32'h1C00_0040, 2); rvalid = 1'b1; rid = 4'd5; rdata = 32'h5555_AAAA;
        settle(); chk("sr_ar_drop", 32'(arvalid), 32'd0); chk("rid5_no_dok", 32'(ch_data_ok), 32'd0);
        chk("busy_no_aok", 32'(ch_addr_ok), 32'd0);
        tick(); clr(0); rid = 4'd0; rdata = 32'hDEAD_BEEF;
        settle(); chk("sr_dok", 32'(ch_data_ok), 32'b001);
        tick(); rvalid = 1'b0;
        settle(); chk("sr_rdata", ch_rdata[31:0], 32'hDEAD_BEEF); chk("sr_dok_pulse", 32'(ch_data_ok), 32'd0);

        // Write with separate AW/W handshakes and a hazarded read on ch0
        tick(); wr(1, 32'h100, 2'd1, 4'b0011, 32'hCAFE_F00D);
        settle(); chk("wr_aok", 32'(ch_addr_ok), 32'b010);
        tick(); clr(1); rd(0, 32'h102, 2'd1); awready = 1'b1;
        settle(); chk("wr_awvalid", 32'(awvalid), 32'd1); chk("wr_wvalid", 32'(wvalid), 32'd1);
        chk("wr_awaddr", awaddr, 32'h100); chk("wr_awsize", 32'(awsize), 32'b001);
        chk("wr_awid", 32'(awid), 32'd1); chk("wr_wid", 32'(wid), 32'd1);
        chk("wr_wstrb", 32'(wstrb), 32'b0011); chk("wr_wdata", wdata, 32'hCAFE_F00D);
        chk("wr_wlast", 32'(wlast), 32'd1); chk("haz_t1", 32'(ch_addr_ok), 32'd0);
        tick(); awready = 1'b0;
        settle(); chk("wr_aw_drop", 32'(awvalid), 32'd0); chk("wr_w_hold", 32'(wvalid), 32'd1);
        chk("haz_t2", 32'(ch_addr_ok), 32'd0);
        tick(); wready = 1'b1;
        settle(); chk("wr_w_t3", 32'(wvalid), 32'd1); chk("haz_t3", 32'(ch_addr_ok), 32'd0);
        tick(); wready = 1'b0;
        settle(); chk("wr_w_drop", 32'(wvalid), 32'd0); chk("haz_t4", 32'(ch_addr_ok), 32'd0);
        tick(); bvalid = 1'b1; bid = 4'd1;
        settle(); chk("wr_dok", 32'(ch_data_ok), 32'b010); chk("haz_t5", 32'(ch_addr_ok), 32'd0);
        tick(); bvalid = 1'b0;
        settle(); chk("haz_release", 32'(ch_addr_ok), 32'b001); chk("wr_dok_pulse", 32'(ch_data_ok), 32'd0);
        tick(); clr(0); arready = 1'b1;
        settle(); chk("haz_araddr", araddr, 32'h102); chk("haz_arsize", 32'(arsize), 32'b001);
        tick(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0BAD_F00D;
        settle(); chk("haz_dok", 32'(ch_data_ok), 32'b001);
        tick(); rvalid = 1'b0;

        // Different word while the slot is occupied goes straight through
        tick(); wr(1, 32'h100, 2'd2, 4'b1111, 32'h1234_5678);
        settle(); chk("wr2_aok", 32'(ch_addr_ok), 32'b010);
        tick(); clr(1); rd(0, 32'h104, 2'd2); awready = 1'b1; wready = 1'b1;
        settle(); chk("nohaz_aok", 32'(ch_addr_ok), 32'b001);
        tick(); clr(0); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd1;
        settle(); chk("wr2_dok", 32'(ch_data_ok), 32'b010); chk("wr2_aw_drop", 32'(awvalid), 32'd0);
        chk("wr2_w_drop", 32'(wvalid), 32'd0); chk("nohaz_arvalid", 32'(arvalid), 32'd1);
        chk("nohaz_araddr", araddr, 32'h104);

        // Reset with a read outstanding and arvalid high
        tick(); bvalid = 1'b0;
        #1 aresetn = 1'b0;
        #1; chk("arst_arvalid", 32'(arvalid), 32'd0); chk("arst_awvalid", 32'(awvalid), 32'd0);
        #3 aresetn = 1'b1;
        tick(); rvalid = 1'b1; rid = 4'd0; rdata = 32'hFFFF_FFFF;
        settle(); chk("arst_no_dok", 32'(ch_data_ok), 32'd0); chk("arst_rdata", ch_rdata[31:0], 32'd0);
        tick(); rvalid = 1'b0; rd(0, 32'h200, 2'd2);
        settle(); chk("arst_busy_clr", 32'(ch_addr_ok), 32'b001);
        tick(); clr(0);
        settle(); chk("arst_arvalid2", 32'(arvalid), 32'd1); chk("arst_araddr2", araddr, 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
